// File: rtl/vdg_pixel_shifter_pkg.sv
// vdg_pixel_shifter_pkg: shared widths and colour constants for the VDG pixel path.
package vdg_pixel_shifter_pkg;
   localparam int COLOUR_W     = 4;
   localparam int PIX_PER_CHAR = 8;
   localparam int BIT_W        = 3;
   localparam int REP_W        = 2;
   localparam logic [3:0] CLR_BLACK   = 4'd0;
   localparam logic [3:0] CLR_SG_BASE = 4'd1;
endpackage

// File: rtl/vdg_pattern_hold.sv
// vdg_pattern_hold: single-entry valid/ready holding register for pattern, Fg and Bg.
module vdg_pattern_hold
   import vdg_pixel_shifter_pkg::*;
#(
   parameter int COLOUR_W = 4
) (
   input  logic                    Clk,
   input  logic                    nReset,
   input  logic [PIX_PER_CHAR-1:0] PatData,
   input  logic [COLOUR_W-1:0]     FgColour,
   input  logic [COLOUR_W-1:0]     BgColour,
   input  logic                    PatValid,
   output logic                    PatReady,
   input  logic                    take,
   output logic [PIX_PER_CHAR-1:0] hold_data,
   output logic [COLOUR_W-1:0]     hold_fg,
   output logic [COLOUR_W-1:0]     hold_bg,
   output logic                    hold_full
);
   // Ready is a pure register output; take only fires while full, so accept and take never collide.
   assign PatReady = !hold_full;
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         hold_fg   <= '0;
         hold_bg   <= '0;
      end else if (PatValid && !hold_full) begin
         hold_full <= 1'b1;
         hold_data <= PatData;
         hold_fg   <= FgColour;
         hold_bg   <= BgColour;
      end else if (take) begin
         hold_full <= 1'b0;
      end
   end
endmodule

// File: rtl/vdg_pixel_shifter.sv
// vdg_pixel_shifter: double-buffered MSB-first pattern serialiser with border, repeat and underrun.
module vdg_pixel_shifter
   import vdg_pixel_shifter_pkg::*;
#(
   parameter int PIXEL_REPEAT = 1,
   parameter int COLOUR_W     = vdg_pixel_shifter_pkg::COLOUR_W
) (
   input  logic                    Clk,
   input  logic                    nReset,
   input  logic                    PixEn,
   input  logic [PIX_PER_CHAR-1:0] PatData,
   input  logic [COLOUR_W-1:0]     FgColour,
   input  logic [COLOUR_W-1:0]     BgColour,
   input  logic                    PatValid,
   output logic                    PatReady,
   input  logic                    Blank,
   input  logic [COLOUR_W-1:0]     BorderColour,
   input  logic                    UnderrunClr,
   output logic [COLOUR_W-1:0]     PixColour,
   output logic                    PixActive,
   output logic                    Underrun
);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(PIXEL_REPEAT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIX_PER_CHAR - 1);

   logic [PIX_PER_CHAR-1:0] hold_data, sh_data;
   logic [COLOUR_W-1:0]     hold_fg, hold_bg, sh_fg, sh_bg;
   logic                    hold_full, sh_empty, boundary, load, under;
   logic [BIT_W-1:0]        bit_cnt;
   logic [REP_W-1:0]        rep_cnt;

   assign boundary = sh_empty || (bit_cnt == BIT_LAST && rep_cnt == REP_LAST);
   assign load     = PixEn && !Blank && boundary && hold_full;
   assign under    = PixEn && !Blank && boundary && !hold_full;

   vdg_pattern_hold #(.COLOUR_W(COLOUR_W)) u_hold (
      .Clk(Clk), .nReset(nReset), .PatData(PatData), .FgColour(FgColour),
      .BgColour(BgColour), .PatValid(PatValid), .PatReady(PatReady), .take(load),
      .hold_data(hold_data), .hold_fg(hold_fg), .hold_bg(hold_bg), .hold_full(hold_full)
   );

   always_ff @(posedge Clk) begin
      if (!nReset) begin
         PixColour <= COLOUR_W'(CLR_BLACK);
         PixActive <= 1'b0;
         Underrun  <= 1'b0;
         sh_empty  <= 1'b1;
         bit_cnt   <= '0;
         rep_cnt   <= '0;
         sh_data   <= '0;
         sh_fg     <= '0;
         sh_bg     <= '0;
      end else begin
         Underrun <= under || (Underrun && !UnderrunClr);
         if (PixEn) begin
            if (Blank || under) begin
               // Border output; any partial character is dropped, hold is left alone.
               PixColour <= BorderColour;
               PixActive <= 1'b0;
               sh_empty  <= 1'b1;
               bit_cnt   <= '0;
               rep_cnt   <= '0;
            end else if (load) begin
               PixColour <= hold_data[PIX_PER_CHAR-1] ? hold_fg : hold_bg;
               PixActive <= 1'b1;
               sh_empty  <= 1'b0;
               bit_cnt   <= '0;
               rep_cnt   <= '0;
               sh_data   <= hold_data;
               sh_fg     <= hold_fg;
               sh_bg     <= hold_bg;
            end else if (rep_cnt != REP_LAST) begin
               rep_cnt <= rep_cnt + 1'b1;
            end else begin
               rep_cnt   <= '0;
               bit_cnt   <= bit_cnt + 1'b1;
               sh_data   <= sh_data << 1;
               PixColour <= sh_data[PIX_PER_CHAR-2] ? sh_fg : sh_bg;
            end
         end
      end
   end
endmodule

// File: tb/tb_vdg_pixel_shifter.sv
// tb_vdg_pixel_shifter: directed checks of serialisation, repeat, underrun, blanking and reset.
module tb_vdg_pixel_shifter;
   logic       Clk = 1'b0;
   logic       nReset, PixEn, PatValid, Blank, UnderrunClr;
   logic [7:0] PatData;
   logic [3:0] FgColour, BgColour, BorderColour;
   logic [3:0] pix1, pix2;
   logic       act1, act2, rdy1, rdy2, und1, und2;
   int         total = 0;
   int         bad = 0;

   always #5 Clk = ~Clk;

   vdg_pixel_shifter #(.PIXEL_REPEAT(1)) dut1 (
      .Clk(Clk), .nReset(nReset), .PixEn(PixEn), .PatData(PatData), .FgColour(FgColour),
      .BgColour(BgColour), .PatValid(PatValid), .PatReady(rdy1), .Blank(Blank),
      .BorderColour(BorderColour), .UnderrunClr(UnderrunClr), .PixColour(pix1),
      .PixActive(act1), .Underrun(und1)
   );

   vdg_pixel_shifter #(.PIXEL_REPEAT(2)) dut2 (
      .Clk(Clk), .nReset(nReset), .PixEn(PixEn), .PatData(PatData), .FgColour(FgColour),
      .BgColour(BgColour), .PatValid(PatValid), .PatReady(rdy2), .Blank(Blank),
      .BorderColour(BorderColour), .UnderrunClr(UnderrunClr), .PixColour(pix2),
      .PixActive(act2), .Underrun(und2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      nReset = 1'b0; PixEn = 1'b0; PatValid = 1'b0; Blank = 1'b0; UnderrunClr = 1'b0;
      step();
      nReset = 1'b1;
   endtask

   task automatic offer(input logic [7:0] d, input logic [3:0] fg, input logic [3:0] bg);
      PatData = d; FgColour = fg; BgColour = bg; PatValid = 1'b1;
   endtask

   initial begin
      logic [3:0] seq1 [8]  = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
      logic [3:0] seq2 [16] = '{4'd5, 4'd1, 4'd5, 4'd1, 4'd5, 4'd1, 4'd5, 4'd1,
                                4'd1, 4'd1, 4'd1, 4'd1, 4'd5, 4'd5, 4'd5, 4'd5};
      PatData = 8'h00; FgColour = 4'd0; BgColour = 4'd0; BorderColour = 4'd0;
      do_reset();
      chk("rst_colour", 32'(pix1), 0);
      chk("rst_active", 32'(act1), 0);
      chk("rst_ready", 32'(rdy1), 1);
      chk("rst_underrun", 32'(und1), 0);

      // single pattern F0
      offer(8'hF0, 4'd3, 4'd0);
      step();
      chk("t1_ready_full", 32'(rdy1), 0);
      PatValid = 1'b0; PixEn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("t1_pix%0d", i), 32'(pix1), 32'(seq1[i]));
         chk($sformatf("t1_act%0d", i), 32'(act1), 1);
         if (i == 0) chk("t1_ready_after_load", 32'(rdy1), 1);
      end

      // back-to-back AA then 0F
      do_reset();
      offer(8'hAA, 4'd5, 4'd1);
      step();
      PatData = 8'h0F; PixEn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("t2_pix%0d", i), 32'(pix1), 32'(seq2[i]));
         chk($sformatf("t2_act%0d", i), 32'(act1), 1);
      end
      chk("t2_underrun", 32'(und1), 0);

      // repeat=2 on dut2, PixEn every other cycle
      do_reset();
      offer(8'h80, 4'd7, 4'd0);
      step();
      PatValid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         PixEn = 1'b1;
         step();
         chk($sformatf("t3_pix%0d", i), 32'(pix2), (i < 2) ? 32'd7 : 32'd0);
         PixEn = 1'b0;
         step();
         chk($sformatf("t3_hold%0d", i), 32'(pix2), (i < 2) ? 32'd7 : 32'd0);
      end
      chk("t3_active", 32'(act2), 1);

      // underrun and clear
      do_reset();
      BorderColour = 4'd2;
      offer(8'hF0, 4'd3, 4'd0);
      step();
      PatValid = 1'b0; PixEn = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("t4_last_pix", 32'(pix1), 0);
      chk("t4_no_under_yet", 32'(und1), 0);
      step();
      chk("t4_border", 32'(pix1), 2);
      chk("t4_inactive", 32'(act1), 0);
      chk("t4_underrun", 32'(und1), 1);
      UnderrunClr = 1'b1;
      step();
      chk("t4_set_wins", 32'(und1), 1);
      UnderrunClr = 1'b0;
      offer(8'hF0, 4'd3, 4'd0);
      step();
      chk("t4_sticky_accept", 32'(und1), 1);
      PatValid = 1'b0;
      step();
      chk("t4_resume_pix", 32'(pix1), 3);
      chk("t4_resume_act", 32'(act1), 1);
      chk("t4_sticky_resume", 32'(und1), 1);
      UnderrunClr = 1'b1;
      step();
      chk("t4_cleared", 32'(und1), 0);
      UnderrunClr = 1'b0;

      // blanking mid-character with next pattern held
      do_reset();
      BorderColour = 4'd6;
      offer(8'hFF, 4'd4, 4'd0);
      step();
      offer(8'h3C, 4'd9, 4'd1);
      PixEn = 1'b1;
      step();
      chk("t5_p0", 32'(pix1), 4);
      step();
      PatValid = 1'b0;
      step();
      chk("t5_p2", 32'(pix1), 4);
      chk("t5_hold_full", 32'(rdy1), 0);
      Blank = 1'b1;
      step();
      chk("t5_blank0", 32'(pix1), 6);
      chk("t5_blank_act", 32'(act1), 0);
      step();
      chk("t5_blank1", 32'(pix1), 6);
      Blank = 1'b0;
      step();
      chk("t5_resume_bit7", 32'(pix1), 1);
      chk("t5_resume_act", 32'(act1), 1);
      chk("t5_no_under", 32'(und1), 0);
      step();
      chk("t5_bit6", 32'(pix1), 1);
      step();
      chk("t5_bit5", 32'(pix1), 9);

      // reset mid-character with the hold full
      offer(8'hAA, 4'd5, 4'd1);
      step();
      PatValid = 1'b0;
      chk("t6_hold_full", 32'(rdy1), 0);
      nReset = 1'b0;
      step();
      chk("t6_rst_colour", 32'(pix1), 0);
      chk("t6_rst_active", 32'(act1), 0);
      chk("t6_rst_ready", 32'(rdy1), 1);
      chk("t6_rst_under", 32'(und1), 0);
      nReset = 1'b1;
      step();
      chk("t6_discarded", 32'(pix1), 6);
      chk("t6_discarded_act", 32'(act1), 0);
      chk("t6_under", 32'(und1), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
